// File: rtl/pio_gpio_ctrl.sv
// Avalon-MM GPIO slave: output register with set/clear, one-shot pulse, synchronised inputs with edge IRQ.
// Latency: zero-wait reads; writes land at the sampling edge; input edges reach EDGE_CAP SYNC_STAGES+1 edges later.
// Backpressure: none, the slave accepts every access in a single cycle.
module pio_gpio_ctrl #(
   parameter int               WIDTH       = 3,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               PULSE_CNT_W = 16,
   parameter int               SYNC_STAGES = 2,
   parameter int               EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_IN    = 3'd1;
   localparam logic [2:0] ADDR_MASK  = 3'd2;
   localparam logic [2:0] ADDR_EDGE  = 3'd3;
   localparam logic [2:0] ADDR_SET   = 3'd4;
   localparam logic [2:0] ADDR_CLR   = 3'd5;
   localparam logic [2:0] ADDR_PLEN  = 3'd6;
   localparam logic [2:0] ADDR_PULSE = 3'd7;

   typedef enum logic {IDLE, ACTIVE} state_e;

   logic                   wr_en;
   logic [WIDTH-1:0]       wd;
   logic [PULSE_CNT_W-1:0] wd_len;
   logic                   unused_wd;

   logic [WIDTH-1:0]       data_q, data_d;
   logic [WIDTH-1:0]       mask_q, mask_d;
   logic [WIDTH-1:0]       cap_q, cap_d;
   logic [PULSE_CNT_W-1:0] len_q, len_d;

   state_e                 state_q;
   logic [PULSE_CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0]       pmask_q;
   logic                   busy;

   logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]       prev_q;
   logic [WIDTH-1:0]       sync_last, rise, fall, edge_set, cap_clr;

   assign wr_en     = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign wd_len    = writedata[PULSE_CNT_W-1:0];
   assign unused_wd = ^writedata;
   assign busy      = (state_q == ACTIVE);

   always_comb begin
      data_d = data_q;
      mask_d = mask_q;
      len_d  = len_q;
      if (wr_en) begin
         case (address)
            ADDR_DATA: data_d = wd;
            ADDR_SET:  data_d = data_q | wd;
            ADDR_CLR:  data_d = data_q & ~wd;
            ADDR_MASK: mask_d = wd;
            ADDR_PLEN: len_d  = wd_len;
            default: ;
         endcase
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign rise      = sync_last & ~prev_q;
   assign fall      = ~sync_last & prev_q;
   assign edge_set  = (EDGE_TYPE == 0) ? rise : (EDGE_TYPE == 1) ? fall : (rise | fall);
   assign cap_clr   = (wr_en && address == ADDR_EDGE) ? wd : '0;
   // A new edge in the same cycle as a write-1-clear keeps the bit set.
   assign cap_d     = (cap_q & ~cap_clr) | edge_set;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= RESET_VALUE;
         mask_q <= '0;
         cap_q  <= '0;
         len_q  <= '0;
         prev_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         data_q    <= data_d;
         mask_q    <= mask_d;
         cap_q     <= cap_d;
         len_q     <= len_d;
         prev_q    <= sync_last;
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Counter is loaded with the length and the pulse ends on the edge where it reads 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pmask_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (wr_en && address == ADDR_PULSE && len_q != '0 && wd != '0) begin
                  state_q <= ACTIVE;
                  cnt_q   <= len_q;
                  pmask_q <= wd;
               end
            end
            ACTIVE: begin
               if (cnt_q == PULSE_CNT_W'(1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  pmask_q <= '0;
               end else begin
                  cnt_q <= cnt_q - PULSE_CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_port = data_q ^ (busy ? pmask_q : '0);
   assign irq      = |(cap_q & mask_q);

   always_comb begin
      readdata = '0;
      if (chipselect) begin
         case (address)
            ADDR_DATA:  readdata = 32'(data_q);
            ADDR_IN:    readdata = 32'(sync_last);
            ADDR_MASK:  readdata = 32'(mask_q);
            ADDR_EDGE:  readdata = 32'(cap_q);
            ADDR_PLEN:  readdata = 32'(len_q);
            ADDR_PULSE: readdata = {31'b0, busy};
            default:    readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_pio_gpio_ctrl.sv
// Directed bench for pio_gpio_ctrl with WIDTH=8, RESET_VALUE=0xA5, two synchroniser stages, rising-edge capture.
module tb_pio_gpio_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic        irq;

   int n_checks = 0;
   int n_pass   = 0;

   pio_gpio_ctrl #(
      .WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_CNT_W(16), .SYNC_STAGES(2), .EDGE_TYPE(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .out_port(out_port), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Called at a falling edge; returns at the next falling edge with the write sampled.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      #1 d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(tag, d, exp);
   endtask

   initial begin
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;
      repeat (2) @(negedge clk);
      chk("rst_out", 32'(out_port), 32'hA5);
      chk("rst_irq", 32'(irq), 32'h0);
      rd_chk("rst_mask", 3'd2, 32'h0);
      rd_chk("rst_cap",  3'd3, 32'h0);
      rd_chk("rst_plen", 3'd6, 32'h0);
      rd_chk("rst_busy", 3'd7, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Output register write, set and clear on successive cycles
      wr(3'd0, 32'h0F);  chk("data_wr", 32'(out_port), 32'h0F);
      wr(3'd4, 32'h30);  chk("outset",  32'(out_port), 32'h3F);
      wr(3'd5, 32'h03);  chk("outclr",  32'(out_port), 32'h3C);
      rd_chk("data_rd", 3'd0, 32'h3C);
      rd_chk("outset_rd_zero", 3'd4, 32'h0);

      // Five-cycle pulse on bits 7 and 0
      wr(3'd6, 32'h5);
      rd_chk("plen_rd", 3'd6, 32'h5);
      wr(3'd7, 32'h81);
      chk("pulse_c0", 32'(out_port), 32'hBD);
      rd_chk("busy_on", 3'd7, 32'h1);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("pulse_c%0d", i), 32'(out_port), 32'hBD);
      end
      @(negedge clk);
      chk("pulse_end", 32'(out_port), 32'h3C);
      rd_chk("busy_off", 3'd7, 32'h0);

      // Ignored re-trigger and base update during a pulse
      wr(3'd7, 32'h81);  chk("p2_c0", 32'(out_port), 32'hBD);
      wr(3'd7, 32'h02);  chk("p2_ignore", 32'(out_port), 32'hBD);
      wr(3'd0, 32'h00);  chk("p2_base0", 32'(out_port), 32'h81);
      @(negedge clk);    chk("p2_c3", 32'(out_port), 32'h81);
      @(negedge clk);    chk("p2_c4", 32'(out_port), 32'h81);
      @(negedge clk);    chk("p2_end", 32'(out_port), 32'h00);
      rd_chk("p2_busy", 3'd7, 32'h0);

      // Zero length suppresses the pulse
      wr(3'd6, 32'h0);
      wr(3'd7, 32'hFF);
      chk("len0_out", 32'(out_port), 32'h00);
      rd_chk("len0_busy", 3'd7, 32'h0);

      // Rising edge capture and interrupt
      wr(3'd2, 32'h01);
      in_port = 8'h01;
      repeat (2) @(negedge clk);
      rd_chk("in_2edges", 3'd1, 32'h01);
      rd_chk("cap_early", 3'd3, 32'h0);
      chk("irq_early", 32'(irq), 32'h0);
      @(negedge clk);
      rd_chk("cap_rise", 3'd3, 32'h01);
      chk("irq_rise", 32'(irq), 32'h1);
      wr(3'd3, 32'h01);
      chk("irq_clr", 32'(irq), 32'h0);
      rd_chk("cap_clr", 3'd3, 32'h0);
      in_port = 8'h00;
      repeat (4) @(negedge clk);
      rd_chk("cap_fall", 3'd3, 32'h0);
      chk("irq_fall", 32'(irq), 32'h0);

      // Clear colliding with a new edge: set wins
      in_port = 8'h01;
      repeat (2) @(negedge clk);
      wr(3'd3, 32'h01);
      rd_chk("cap_collide", 3'd3, 32'h01);
      chk("irq_collide", 32'(irq), 32'h1);
      in_port = 8'h00;
      repeat (3) @(negedge clk);

      // Reset in the middle of a pulse
      wr(3'd6, 32'd10);
      wr(3'd7, 32'h0F);
      chk("rp_active", 32'(out_port), 32'h0F);
      #2 reset_n = 1'b0;
      #1 chk("rp_async_out", 32'(out_port), 32'hA5);
      rd_chk("rp_async_busy", 3'd7, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         chk("rp_after", 32'(out_port), 32'hA5);
      end
      rd_chk("rp_busy", 3'd7, 32'h0);
      rd_chk("rp_plen", 3'd6, 32'h0);
      chk("rp_irq", 32'(irq), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
